display_scan_controller: RTL and testbench

Time-multiplexing scheduler that shares one seven-segment decoder among `N_DIGITS` common-anode digits. It steps through the digits in a fixed round-robin scan. Each digit slot has a blanking interval followed by a drive interval, to prevent ghosting. New display contents are accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never shows mixed old and new data. The block sits between the lab top level (switch/data sources) and the shared `seven_seg` decoder plus the PNP anode drivers.

---
 rtl/display_pkg.sv | 19 +
 rtl/scan_timer.sv | 35 +++
 rtl/display_scan_controller.sv | 138 +++++++++++++
 tb/tb_display_scan_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package display_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 32;

    // All anodes off; slice to the digit count in use.
    localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

    function automatic int dwell_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable dwell down-counter; tc flags the last cycle of the current dwell.
module scan_timer #(
    parameter int               CNT_W     = 8,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Round-robin digit scanner with blank/drive slots and frame-aligned image updates.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_CYCLES  = 10000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         upd_valid,
    input  logic [NIBBLE_W*N_DIGITS-1:0] upd_data,
    input  logic [N_DIGITS-1:0]          upd_mask,
    output logic                         upd_ready,
    output logic [NIBBLE_W-1:0]          nibble,
    output logic [N_DIGITS-1:0]          anode_n,
    output logic [$clog2(N_DIGITS)-1:0]  digit_idx,
    output logic                         frame_done
);

    localparam int IDX_W  = $clog2(N_DIGITS);
    localparam int CNT_W  = $clog2(dwell_max(SCAN_CYCLES, BLANK_CYCLES) + 1);
    localparam int DATA_W = NIBBLE_W * N_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SCAN_LOAD  = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);

    scan_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   active_data_q, active_data_d;
    logic [N_DIGITS-1:0] active_mask_q, active_mask_d;
    logic [DATA_W-1:0]   stage_data_q, stage_data_d;
    logic [N_DIGITS-1:0] stage_mask_q, stage_mask_d;
    logic                pending_q, pending_d;
    logic [N_DIGITS-1:0] anode_q, anode_d;
    logic [NIBBLE_W-1:0] nibble_q, nibble_d;
    logic                frame_done_q, frame_done_d;
    logic                tc;
    logic                wrap;
    logic [CNT_W-1:0]    load_val;

    // Reload tracks the state being entered, so the counter restarts on every transition.
    scan_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (BLANK_LOAD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tc),
        .load_val (load_val),
        .tc       (tc)
    );

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        active_data_d = active_data_q;
        active_mask_d = active_mask_q;
        stage_data_d  = stage_data_q;
        stage_mask_d  = stage_mask_q;
        pending_d     = pending_q;
        nibble_d      = nibble_q;
        frame_done_d  = 1'b0;
        wrap          = 1'b0;

        if (tc) begin
            if (state_q == S_BLANK) begin
                state_d = S_DRIVE;
            end else begin
                state_d = S_BLANK;
                if (idx_q == LAST_IDX) begin
                    idx_d        = '0;
                    wrap         = 1'b1;
                    frame_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end

        // Staging is only writable while empty, so capture and apply never coincide.
        if (upd_valid && !pending_q) begin
            stage_data_d = upd_data;
            stage_mask_d = upd_mask;
            pending_d    = 1'b1;
        end else if (wrap && pending_q) begin
            active_data_d = stage_data_q;
            active_mask_d = stage_mask_q;
            pending_d     = 1'b0;
        end

        if (tc && state_q == S_DRIVE) begin
            nibble_d = active_data_d[int'(idx_d)*NIBBLE_W +: NIBBLE_W];
        end

        anode_d = ANODES_OFF[N_DIGITS-1:0];
        if (state_d == S_DRIVE) begin
            anode_d[idx_d] = ~active_mask_d[idx_d];
        end

        load_val = (state_d == S_DRIVE) ? SCAN_LOAD : BLANK_LOAD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_BLANK;
            idx_q         <= '0;
            active_data_q <= '0;
            active_mask_q <= '0;
            stage_data_q  <= '0;
            stage_mask_q  <= '0;
            pending_q     <= 1'b0;
            anode_q       <= ANODES_OFF[N_DIGITS-1:0];
            nibble_q      <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            active_data_q <= active_data_d;
            active_mask_q <= active_mask_d;
            stage_data_q  <= stage_data_d;
            stage_mask_q  <= stage_mask_d;
            pending_q     <= pending_d;
            anode_q       <= anode_d;
            nibble_q      <= nibble_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign upd_ready  = ~pending_q;
    assign nibble     = nibble_q;
    assign anode_n    = anode_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed and random stimulus for display_scan_controller against a cycle-index reference model.
module tb_display_scan_controller;

    localparam int N     = 4;
    localparam int SCAN  = 8;
    localparam int BLANK = 2;
    localparam int SLOT  = SCAN + BLANK;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic [3:0]  upd_mask;
    logic        upd_ready;
    logic [3:0]  nibble;
    logic [3:0]  anode_n;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int t      = 0;

    // Reference model: displayed and staged images, cycle index since reset release.
    logic [15:0] m_act_d, m_stg_d;
    logic [3:0]  m_act_m, m_stg_m;
    logic        m_pend;

    logic [15:0] img_a, img_b, img_c, img_e, img_g;
    logic [3:0]  exp_nib;

    display_scan_controller #(
        .N_DIGITS     (N),
        .SCAN_CYCLES  (SCAN),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_data   (upd_data),
        .upd_mask   (upd_mask),
        .upd_ready  (upd_ready),
        .nibble     (nibble),
        .anode_n    (anode_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act_d = '0;
        m_act_m = '0;
        m_stg_d = '0;
        m_stg_m = '0;
        m_pend  = 1'b0;
        t       = 0;
    endtask

    task automatic compare_model();
        int         slot;
        int         pos;
        logic [3:0] exp_an;
        slot   = (t / SLOT) % N;
        pos    = t % SLOT;
        exp_an = 4'hF;
        if (pos >= BLANK) exp_an[slot] = ~m_act_m[slot];
        check("digit_idx", 32'(digit_idx), 32'(slot));
        check("anode_n", 32'(anode_n), 32'(exp_an));
        check("nibble", 32'(nibble), 32'(m_act_d[slot*4 +: 4]));
        check("frame_done", 32'(frame_done), 32'((t > 0) && (t % FRAME == 0)));
        check("upd_ready", 32'(upd_ready), 32'(!m_pend));
    endtask

    // One clock cycle: check outputs for cycle t, drive inputs, advance model across the edge.
    task automatic step(input logic v, input logic [15:0] d, input logic [3:0] m);
        compare_model();
        upd_valid = v;
        upd_data  = d;
        upd_mask  = m;
        if (m_pend && ((t + 1) % FRAME == 0)) begin
            m_act_d = m_stg_d;
            m_act_m = m_stg_m;
            m_pend  = 1'b0;
        end else if (v && !m_pend) begin
            m_stg_d = d;
            m_stg_m = m;
            m_pend  = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        upd_valid = 1'b0;
        upd_data  = '0;
        upd_mask  = '0;
        repeat (2) @(negedge clk);
        check("rst_anode", 32'(anode_n), 32'h0000_000F);
        check("rst_nibble", 32'(nibble), 32'h0);
        check("rst_ready", 32'(upd_ready), 32'h1);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_idx", 32'(digit_idx), 32'h0);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        reset     = 1'b0;
        upd_valid = 1'b0;
        upd_data  = '0;
        upd_mask  = '0;
        model_reset();

        // Idle scan: anodes dark, index walks, boundary pulses at 40 and 80.
        do_reset();
        idle(40);
        check("idle_fd40", 32'(frame_done), 32'h1);
        idle(40);
        check("idle_fd80", 32'(frame_done), 32'h1);

        // First image 4321/F sent at cycle 5.
        do_reset();
        idle(5);
        step(1'b1, 16'h4321, 4'hF);
        check("s2_ready_t6", 32'(upd_ready), 32'h0);
        idle(34);
        check("s2_fd_t40", 32'(frame_done), 32'h1);
        check("s2_nib_t40", 32'(nibble), 32'h1);
        check("s2_ready_t40", 32'(upd_ready), 32'h1);
        idle(5);
        check("s2_anode_t45", 32'(anode_n), 32'hE);
        idle(5);
        check("s2_nib_t50", 32'(nibble), 32'h2);

        // Partial mask 0101: slot 0 lit, slot 1 dark, slot 2 lit.
        step(1'b1, 16'($urandom), 4'b0101);
        idle(29);
        idle(5);
        check("s3_anode_slot0", 32'(anode_n), 32'hE);
        idle(10);
        check("s3_anode_slot1", 32'(anode_n), 32'hF);
        idle(10);
        check("s3_anode_slot2", 32'(anode_n), 32'hB);

        // Second image held while pending must wait for ready.
        img_a = 16'($urandom);
        img_b = ~img_a;
        step(1'b1, img_a, 4'hF);
        for (int i = 0; i < 14; i++) step(1'b1, img_b, 4'hF);
        check("s4_ready_t120", 32'(upd_ready), 32'h1);
        exp_nib = img_a[3:0];
        check("s4_nib_a", 32'(nibble), 32'(exp_nib));
        step(1'b1, img_b, 4'hF);
        check("s4_ready_low", 32'(upd_ready), 32'h0);
        idle(39);
        exp_nib = img_b[3:0];
        check("s4_nib_b", 32'(nibble), 32'(exp_nib));

        // Transfer on the boundary cycle itself becomes active one frame later.
        img_c = ~img_b;
        step(1'b1, img_c, 4'hF);
        idle(9);
        exp_nib = img_b[7:4];
        check("s5_nib_old", 32'(nibble), 32'(exp_nib));
        idle(30);
        exp_nib = img_c[3:0];
        check("s5_nib_new", 32'(nibble), 32'(exp_nib));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) == 0, 16'($urandom), 4'($urandom));
        end

        // Asynchronous reset in slot 2 with an update pending.
        do_reset();
        idle(5);
        img_e = 16'($urandom) | 16'h0100;
        img_g = 16'($urandom);
        step(1'b1, img_e, 4'hF);
        idle(54);
        step(1'b1, img_g, 4'hF);
        idle(4);
        check("s6_anode_slot2", 32'(anode_n), 32'hB);
        #2;
        reset = 1'b0;
        #1;
        check("s6_async_anode", 32'(anode_n), 32'hF);
        check("s6_async_nibble", 32'(nibble), 32'h0);
        check("s6_async_ready", 32'(upd_ready), 32'h1);
        check("s6_async_idx", 32'(digit_idx), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        idle(5);
        check("s6_anode_after", 32'(anode_n), 32'hF);
        idle(35);
        check("s6_nib_t40", 32'(nibble), 32'h0);
        check("s6_ready_t40", 32'(upd_ready), 32'h1);
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
